// File: rtl/vga_line_fetch_arbiter.sv
// vga_line_fetch_arbiter
// Prefetches one scanline of pixel words from a shared single-port pixel
// memory into a double-banked line buffer, and shares that memory port with
// host pixel writes. A host write that has waited MAX_HOST_WAIT cycles during
// a fetch is given one memory slot.
//
// Ports
//   i_clk, i_rst        pixel clock, asynchronous active-high reset
//   i_frame_tick        frame-start pulse, clears o_underrun
//   i_line_req          start fetching line i_fetch_y (0..479)
//   i_host_*            host write request (valid/addr/wdata), o_host_ready = issued now
//   o_mem_*             memory strobe/we/addr/wdata (combinational), i_mem_rdata 1 cycle later
//   o_lb_*              line-buffer write port; o_lb_bank = bank being filled
//   o_busy              high while fetching
//   o_fetch_done        pulse on the last line-buffer write of a completed line
//   o_underrun          sticky: line request arrived while a fetch was running
module vga_line_fetch_arbiter #(
    parameter int WORDS_PER_LINE = 40,
    parameter int ADDR_W         = 15,
    parameter int DATA_W         = 16,
    parameter int MAX_HOST_WAIT  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_frame_tick,
    input  logic              i_line_req,
    input  logic [8:0]        i_fetch_y,
    input  logic              i_host_valid,
    output logic              o_host_ready,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic              o_lb_we,
    output logic [6:0]        o_lb_addr,
    output logic [DATA_W-1:0] o_lb_wdata,
    output logic              o_lb_bank,
    output logic              o_busy,
    output logic              o_fetch_done,
    output logic              o_underrun
);

    localparam int WAIT_W = $clog2(MAX_HOST_WAIT + 1);
    localparam logic [5:0]        LAST_WORD = 6'(WORDS_PER_LINE - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_HOST_WAIT);

    typedef enum logic {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_base;
    logic [5:0]          r_word_cnt;
    logic [WAIT_W-1:0]   r_host_wait;
    logic                r_bank;
    logic                r_lb_we;
    logic [6:0]          r_lb_addr;
    logic                r_fetch_done;
    logic                r_underrun;

    logic                w_host_grant;
    logic                w_read_issue;
    logic                w_last_read;
    logic [ADDR_W-1:0]   w_read_addr;
    logic [ADDR_W-1:0]   w_base_next;

    // In IDLE the host owns the port; during a fetch it only wins once starved.
    assign w_host_grant = (r_state == S_IDLE) ? i_host_valid
                                              : (i_host_valid && (r_host_wait == WAIT_MAX));
    assign w_read_issue = (r_state == S_FETCH) && !w_host_grant;
    assign w_last_read  = w_read_issue && (r_word_cnt == LAST_WORD);
    assign w_read_addr  = r_base + ADDR_W'(r_word_cnt);
    assign w_base_next  = ADDR_W'(32'(i_fetch_y) * 32'(WORDS_PER_LINE));

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a line request always (re)starts a fetch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_line_req) w_state_next = S_FETCH;
            S_FETCH: begin
                if (i_line_req)       w_state_next = S_FETCH;
                else if (w_last_read) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Memory port outputs
    always_comb begin
        o_host_ready = w_host_grant;
        o_mem_req    = w_host_grant || w_read_issue;
        o_mem_we     = w_host_grant;
        o_mem_addr   = '0;
        o_mem_wdata  = '0;
        if (w_host_grant) begin
            o_mem_addr  = i_host_addr;
            o_mem_wdata = i_host_wdata;
        end else if (w_read_issue) begin
            o_mem_addr  = w_read_addr;
        end
    end

    // Fetch datapath, host starvation counter and read-return pipeline
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_base       <= '0;
            r_word_cnt   <= '0;
            r_host_wait  <= '0;
            r_bank       <= 1'b0;
            r_lb_we      <= 1'b0;
            r_lb_addr    <= '0;
            r_fetch_done <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            if (i_line_req) begin
                r_base     <= w_base_next;
                r_word_cnt <= '0;
                r_bank     <= ~r_bank;
            end else if (w_read_issue) begin
                r_word_cnt <= r_word_cnt + 6'd1;
            end

            if (i_host_valid && !w_host_grant) begin
                r_host_wait <= (r_host_wait == WAIT_MAX) ? r_host_wait : r_host_wait + 1'b1;
            end else begin
                r_host_wait <= '0;
            end

            // Bank and word are captured with the read so a restart cannot
            // redirect the returning data.
            r_lb_we <= w_read_issue;
            if (w_read_issue) begin
                r_lb_addr <= {r_bank, r_word_cnt};
            end
            // A request arriving with the last read aborts that line.
            r_fetch_done <= w_last_read && !i_line_req;

            if (i_line_req && (r_state == S_FETCH)) begin
                r_underrun <= 1'b1;
            end else if (i_frame_tick) begin
                r_underrun <= 1'b0;
            end
        end
    end

    assign o_lb_we      = r_lb_we;
    assign o_lb_addr    = r_lb_addr;
    assign o_lb_wdata   = r_lb_we ? i_mem_rdata : '0;
    assign o_lb_bank    = r_bank;
    assign o_busy       = (r_state == S_FETCH);
    assign o_fetch_done = r_fetch_done;
    assign o_underrun   = r_underrun;

endmodule

// File: tb/tb_vga_line_fetch_arbiter.sv
module tb_vga_line_fetch_arbiter;

    localparam int WPL  = 40;
    localparam int MAXW = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        line_req = 1'b0;
    logic [8:0]  fetch_y = '0;
    logic        host_valid = 1'b0;
    logic        host_ready;
    logic [14:0] host_addr = '0;
    logic [15:0] host_wdata = '0;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        lb_we;
    logic [6:0]  lb_addr;
    logic [15:0] lb_wdata;
    logic        lb_bank, busy, fetch_done, underrun;

    always #5 clk = ~clk;

    vga_line_fetch_arbiter dut (
        .i_clk(clk), .i_rst(rst), .i_frame_tick(frame_tick), .i_line_req(line_req),
        .i_fetch_y(fetch_y), .i_host_valid(host_valid), .o_host_ready(host_ready),
        .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
        .o_lb_we(lb_we), .o_lb_addr(lb_addr), .o_lb_wdata(lb_wdata),
        .o_lb_bank(lb_bank), .o_busy(busy), .o_fetch_done(fetch_done),
        .o_underrun(underrun)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Behavioural reference: pixel memory contents plus the fetch in progress
    // described as "line base, next word to read, bank being filled".
    logic [15:0] mem [32768];
    bit          m_fetch, m_bank, m_underrun, m_lbwe, m_done;
    int          m_base, m_word, m_wait;
    logic [6:0]  m_lbaddr;
    logic [15:0] m_pend;

    // Expected port behaviour for the current cycle
    bit          e_ready, e_read;
    int          e_addr, e_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_fetch = 0; m_bank = 0; m_underrun = 0; m_lbwe = 0; m_done = 0;
        m_base = 0; m_word = 0; m_wait = 0; m_lbaddr = '0; m_pend = '0;
    endtask

    task automatic eval_and_check();
        e_ready = 0; e_read = 0; e_addr = 0; e_wdata = 0;
        if (!m_fetch || (m_wait == MAXW)) begin
            if (host_valid) begin
                e_ready = 1; e_addr = int'(host_addr); e_wdata = int'(host_wdata);
            end
        end
        if (m_fetch && !e_ready) begin
            e_read = 1;
            e_addr = (m_base + m_word) % 32768;
        end
        check("host_ready", 32'(host_ready), 32'(e_ready));
        check("mem_req",    32'(mem_req),    32'(e_ready | e_read));
        check("mem_we",     32'(mem_we),     32'(e_ready));
        check("mem_addr",   32'(mem_addr),   32'(e_addr));
        check("mem_wdata",  32'(mem_wdata),  32'(e_wdata));
        check("lb_we",      32'(lb_we),      32'(m_lbwe));
        check("lb_addr",    32'(lb_addr),    32'(m_lbaddr));
        check("lb_wdata",   32'(lb_wdata),   m_lbwe ? 32'(m_pend) : 32'd0);
        check("lb_bank",    32'(lb_bank),    32'(m_bank));
        check("busy",       32'(busy),       32'(m_fetch));
        check("fetch_done", 32'(fetch_done), 32'(m_done));
        check("underrun",   32'(underrun),   32'(m_underrun));
    endtask

    task automatic model_update();
        logic [5:0] wlow;
        if (e_ready) mem[host_addr] = host_wdata;
        if (e_read) begin
            wlow     = 6'(m_word);
            m_pend   = mem[e_addr];
            m_lbwe   = 1;
            m_lbaddr = {m_bank, wlow};
            m_done   = (m_word == WPL - 1) && !line_req;
        end else begin
            m_lbwe = 0;
            m_done = 0;
        end
        if (host_valid && !e_ready) m_wait = (m_wait < MAXW) ? m_wait + 1 : MAXW;
        else                        m_wait = 0;
        if (line_req && m_fetch) m_underrun = 1;
        else if (frame_tick)     m_underrun = 0;
        if (line_req) begin
            m_fetch = 1;
            m_base  = (int'(fetch_y) * WPL) % 32768;
            m_word  = 0;
            m_bank  = ~m_bank;
        end else if (e_read) begin
            m_word++;
            if (m_word == WPL) m_fetch = 0;
        end
    endtask

    task automatic run_cycle(input bit lr, input int fy, input bit hv,
                             input int ha, input int hd, input bit ft);
        @(negedge clk);
        cyc++;
        line_req   = lr;
        fetch_y    = 9'(fy);
        host_valid = hv;
        host_addr  = 15'(ha);
        host_wdata = 16'(hd);
        frame_tick = ft;
        mem_rdata  = m_lbwe ? m_pend : 16'h0000;
        #2;
        eval_and_check();
        if (lr) $display("line_req y=%0d base=%0d cycle %0d busy_before=%0d", fy, (fy * WPL) % 32768, cyc, m_fetch);
        model_update();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) run_cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cyc++;
        rst = 1; line_req = 0; host_valid = 0; frame_tick = 0; mem_rdata = '0;
        #2;
        model_reset();
        eval_and_check();
        $display("reset cycle %0d", cyc);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int k;
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        model_reset();
        do_reset();

        // Plain fetch of line 3
        run_cycle(1, 3, 0, 0, 0, 0);
        idle(45);

        // Host write in IDLE
        run_cycle(0, 0, 1, 'h0100, 'hA5A5, 0);
        $display("host write addr=0100 data=A5A5 ready=%0d", e_ready);
        idle(2);

        // Host held from cycle 1 of a line-0 fetch until it wins a slot
        run_cycle(1, 0, 0, 0, 0, 0);
        k = 0;
        do begin
            run_cycle(0, 0, 1, 'h1234, 'h5A5A, 0);
            k++;
        end while (!e_ready && k < 20);
        check("host_grant_wait", 32'(k), 32'd9);
        idle(45);

        // Underrun: restart at cycle 10, then clear with frame_tick
        run_cycle(1, 5, 0, 0, 0, 0);
        idle(9);
        run_cycle(1, 6, 0, 0, 0, 0);
        idle(45);
        run_cycle(0, 0, 0, 0, 0, 1);
        idle(2);

        // Reset in the middle of a fetch, then a fresh fetch
        run_cycle(1, 3, 0, 0, 0, 0);
        idle(19);
        do_reset();
        run_cycle(1, 3, 0, 0, 0, 0);
        idle(45);

        // Last visible line
        run_cycle(1, 479, 0, 0, 0, 0);
        idle(45);

        // Frame tick and underrun set in the same cycle: set wins
        run_cycle(1, 10, 0, 0, 0, 0);
        idle(5);
        run_cycle(1, 11, 0, 0, 0, 1);
        idle(45);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            run_cycle($urandom_range(0, 59) == 0, $urandom_range(0, 479),
                      $urandom_range(0, 2) == 0, $urandom_range(0, 32767),
                      $urandom_range(0, 65535), $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_line_fetch_arbiter.md
Name: vga_line_fetch_arbiter

Overview:
- Schedules scanline prefetch for the 640x480 video path: on each line request it reads one line of pixel words from a shared single-port pixel memory into a double-banked line buffer.
- Arbitrates the same memory port between prefetch reads and host pixel writes, with a starvation guard for the host.
- Sits between the VGA timing generator (line_req/fetch_y/frame_tick), the pixel SRAM and the line buffer feeding the pixel output stage.

Parameters:
- WORDS_PER_LINE, 40, memory words per scanline (640 px at 1 bpp, 16-bit words)
- ADDR_W, 15, pixel memory word-address width
- DATA_W, 16, memory and line-buffer data width
- MAX_HOST_WAIT, 8, consecutive stalled host cycles before the host is forced a slot during a fetch

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- frame_tick  in  1  1-cycle pulse at frame start; clears underrun
- line_req  in  1  1-cycle pulse: start fetching line fetch_y
- fetch_y  in  9  line index (0..479), sampled when line_req=1
- host_valid  in  1  host write pending
- host_ready  out  1  combinational; host write issued this cycle
- host_addr  in  ADDR_W  host write address
- host_wdata  in  DATA_W  host write data
- mem_req  out  1  combinational memory access strobe
- mem_we  out  1  1 = write (host), 0 = read (fetch)
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  write data (= host_wdata on host grant, else 0)
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after a read strobe
- lb_we  out  1  registered line-buffer write strobe
- lb_addr  out  7  {bank, word[5:0]}
- lb_wdata  out  DATA_W  line-buffer write data (= mem_rdata)
- lb_bank  out  1  bank currently being filled; display reads ~lb_bank
- busy  out  1  1 while in FETCH
- fetch_done  out  1  1-cycle pulse on the final lb_we of a completed line
- underrun  out  1  sticky: line_req arrived while FETCH was active

Behaviour:
- Reset (async, rst=1): state IDLE, word_cnt=0, host_wait=0, lb_bank=0, busy=0, fetch_done=0, underrun=0, lb_we=0, lb_addr=0, lb_wdata=0; combinational outputs are 0 while in IDLE with host_valid=0. Reset mid-fetch discards the fetch and any in-flight read; no lb_we follows.
- States: IDLE, FETCH.
- IDLE + line_req: next cycle FETCH; base <= fetch_y*WORDS_PER_LINE (truncated to ADDR_W); word_cnt <= 0; lb_bank <= ~lb_bank.
- IDLE: host_ready = host_valid; mem_req = host_valid, mem_we = 1, mem_addr = host_addr. This includes the cycle line_req is accepted.
- FETCH slot choice, per cycle:
  - if host_valid and host_wait == MAX_HOST_WAIT: host write granted (host_ready=1, mem_we=1); word_cnt holds.
  - else: read issued, mem_addr = base + word_cnt (mod 2^ADDR_W), word_cnt++.
  - After issuing read WORDS_PER_LINE-1: next state IDLE.
- host_wait: +1 each cycle with host_valid=1 and host_ready=0 (saturates at MAX_HOST_WAIT); 0 on grant or host_valid=0.
- Read pipeline: read issued at cycle t gives, at t+1, lb_we=1, lb_addr={bank at issue, word at issue}, lb_wdata=mem_rdata. The bank and word are captured per read.
- fetch_done=1 in the same cycle as lb_we for word WORDS_PER_LINE-1 of a non-aborted fetch.
- Latency with no host interference: line_req at cycle 0 → reads at cycles 1..40 → lb_we at cycles 2..41 → fetch_done at cycle 41 → busy low from cycle 41.
- line_req during FETCH (underrun):
  - underrun <= 1; fetch restarts with the new fetch_y, word_cnt=0, lb_bank toggles again.
  - An in-flight read still writes to its captured bank/word.
  - No fetch_done for the aborted line.
- frame_tick clears underrun; if frame_tick and underrun set occur in the same cycle, set wins.
- Host address or data changing while host_valid=1 and not granted: no effect until grant (no host-side buffering).

Test Plan:
- Reset, then line_req with fetch_y=3, host idle → mem_addr 120..159 on cycles 1..40; lb_we on cycles 2..41 with lb_addr={1,0..39}; fetch_done only at cycle 41; lb_bank=1.
- Host write (addr 0x0100, data 0xA5A5) in IDLE → host_ready=1 the same cycle, mem_we=1, mem_addr=0x0100, mem_wdata=0xA5A5.
- host_valid held from cycle 1 of a fetch with fetch_y=0 → host_ready exactly at cycle 9; reads resume at address 8 in cycle 10; last read at cycle 41; fetch_done at cycle 42.
- Second line_req at cycle 10 of a fetch with fetch_y=5 → underrun=1; lb_we at cycle 11 still targets bank 1; new reads start at 240 with lb_bank=0; one fetch_done only; frame_tick later clears underrun.
- Assert rst at cycle 20 of a fetch → busy=0, lb_we=0 next cycle, lb_bank=0; a fresh line_req then behaves as in the first scenario.
- fetch_y=479 → mem_addr 19160..19199, no truncation errors at ADDR_W=15.
